// File: rtl/gt_latency_monitor_pkg.sv
// Shared types and constants for the GT latency / link-integrity monitor.
// Contents: FSM state enum, failure cause codes, latency width check helper.
package gt_latency_monitor_pkg;

   typedef enum logic [2:0] {
      S_DOWN,
      S_ALIGN,
      S_BLIND,
      S_SEEK,
      S_CHECK,
      S_PASS,
      S_FAIL
   } state_e;

   localparam logic [2:0] FAIL_NONE       = 3'd0;
   localparam logic [2:0] FAIL_COMMA_BYTE = 3'd1;
   localparam logic [2:0] FAIL_DATA       = 3'd2;
   localparam logic [2:0] FAIL_ALIGN_LOST = 3'd3;
   localparam logic [2:0] FAIL_BUFFER     = 3'd4;

   // Latency is a truncated datapath difference, so it cannot be wider than the datapath.
   function automatic bit lat_width_ok(input int unsigned lat_w, input int unsigned data_w);
      return (lat_w >= 1) && (lat_w <= data_w);
   endfunction

endpackage

// File: rtl/gt_latency_pattern_gen.sv
// TX pattern generator: free-running W-bit counter with one IDLE/comma word per
// g_IDLE_PERIOD words. Runs regardless of the monitor state.
// Ports:
//   usrclk_i, rst_n_i  clock, async active-low reset
//   tx_data_o, tx_k_o  registered word / K flags to the GT TX
//   tx_cnt_o           counter value belonging to the word now on tx_data_o
module gt_latency_pattern_gen
   import gt_latency_monitor_pkg::*;
#(
   parameter int unsigned          g_BYTES       = 2,
   parameter logic [8*g_BYTES-1:0] g_IDLE        = (8*g_BYTES)'(16'hbc95),
   parameter logic [g_BYTES-1:0]   g_IDLE_K      = g_BYTES'(2'b10),
   parameter int unsigned          g_IDLE_PERIOD = 193
) (
   input  logic                   usrclk_i,
   input  logic                   rst_n_i,
   output logic [8*g_BYTES-1:0]   tx_data_o,
   output logic [g_BYTES-1:0]     tx_k_o,
   output logic [8*g_BYTES-1:0]   tx_cnt_o
);

   localparam int unsigned W  = 8 * g_BYTES;
   localparam int unsigned PW = $clog2(g_IDLE_PERIOD);

   logic [W-1:0]       cnt_q, cnt_d;
   logic [PW-1:0]      phase_q, phase_d;
   logic [W-1:0]       tx_data_q, tx_data_d;
   logic [g_BYTES-1:0] tx_k_q, tx_k_d;
   logic [W-1:0]       tx_cnt_q, tx_cnt_d;

   // cnt_q/phase_q describe the word about to be emitted; tx_cnt_q tags the emitted one.
   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      phase_d  = (phase_q == PW'(g_IDLE_PERIOD - 1)) ? '0 : phase_q + 1'b1;
      tx_cnt_d = cnt_q;
      if (phase_q == '0) begin
         tx_data_d = g_IDLE;
         tx_k_d    = g_IDLE_K;
      end else begin
         tx_data_d = cnt_q;
         tx_k_d    = '0;
      end
   end

   always_ff @(posedge usrclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q     <= '0;
         phase_q   <= '0;
         tx_data_q <= '0;
         tx_k_q    <= '0;
         tx_cnt_q  <= '0;
      end else begin
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         tx_data_q <= tx_data_d;
         tx_k_q    <= tx_k_d;
         tx_cnt_q  <= tx_cnt_d;
      end
   end

   assign tx_data_o = tx_data_q;
   assign tx_k_o    = tx_k_q;
   assign tx_cnt_o  = tx_cnt_q;

endmodule

// File: rtl/gt_latency_monitor.sv
// GT TX/RX latency and link-integrity monitor. Drives a counting pattern with
// periodic IDLE words, walks the RX side through realign/blind/seek, then checks
// comma placement and payload continuity and measures min/max/last latency.
// Optional feature: define GT_LATENCY_MONITOR_BUFSTATUS_EN to fail (code 4) on
// rx_bufstatus_i[2] while checking; otherwise rx_bufstatus_i is ignored.
// Ports:
//   usrclk_i, rst_n_i        clock, async active-low reset
//   valid_i, clear_i         link valid / synchronous restart
//   tx_data_o, tx_k_o        pattern to GT TX
//   rx_data_i, rx_k_i        data from GT RX
//   rx_realign_o             comma realign request (S_ALIGN)
//   rx_aligned_i             GT comma alignment status
//   rx_bufstatus_i           GT elastic buffer status
//   pass_o, fail_o, fail_code_o                      sticky verdict and cause
//   latency_last_o, latency_min_o, latency_max_o     latency statistics
//   ok_cnt_o                 saturating good payload word count
module gt_latency_monitor
   import gt_latency_monitor_pkg::*;
#(
   parameter int unsigned          g_BYTES               = 2,
   parameter logic [8*g_BYTES-1:0] g_IDLE                = (8*g_BYTES)'(16'hbc95),
   parameter logic [g_BYTES-1:0]   g_IDLE_K              = g_BYTES'(2'b10),
   parameter int unsigned          g_IDLE_PERIOD         = 193,
   parameter int unsigned          g_BLIND_PERIOD        = 10,
   parameter int unsigned          g_NUM_SUCCESSFUL_DATA = 1000,
   parameter int unsigned          g_LAT_WIDTH           = 16
) (
   input  logic                   usrclk_i,
   input  logic                   rst_n_i,
   input  logic                   valid_i,
   input  logic                   clear_i,
   output logic [8*g_BYTES-1:0]   tx_data_o,
   output logic [g_BYTES-1:0]     tx_k_o,
   input  logic [8*g_BYTES-1:0]   rx_data_i,
   input  logic [g_BYTES-1:0]     rx_k_i,
   output logic                   rx_realign_o,
   input  logic                   rx_aligned_i,
   input  logic [2:0]             rx_bufstatus_i,
   output logic                   pass_o,
   output logic                   fail_o,
   output logic [2:0]             fail_code_o,
   output logic [g_LAT_WIDTH-1:0] latency_last_o,
   output logic [g_LAT_WIDTH-1:0] latency_min_o,
   output logic [g_LAT_WIDTH-1:0] latency_max_o,
   output logic [31:0]            ok_cnt_o
);

   localparam int unsigned W  = 8 * g_BYTES;
   localparam int unsigned BW = (g_BLIND_PERIOD > 0) ? $clog2(g_BLIND_PERIOD + 1) : 1;

   if (!lat_width_ok(g_LAT_WIDTH, W) || !((g_BYTES == 2) || (g_BYTES == 4))) begin : g_bad_params
      $error("gt_latency_monitor: illegal g_BYTES or g_LAT_WIDTH");
   end

   logic [W-1:0] tx_cnt;

   gt_latency_pattern_gen #(
      .g_BYTES       (g_BYTES),
      .g_IDLE        (g_IDLE),
      .g_IDLE_K      (g_IDLE_K),
      .g_IDLE_PERIOD (g_IDLE_PERIOD)
   ) u_pattern_gen (
      .usrclk_i  (usrclk_i),
      .rst_n_i   (rst_n_i),
      .tx_data_o (tx_data_o),
      .tx_k_o    (tx_k_o),
      .tx_cnt_o  (tx_cnt)
   );

   state_e               state_q, state_d;
   logic [BW-1:0]        blind_q, blind_d;
   logic [W-1:0]         prev_q, prev_d;
   logic                 prev_valid_q, prev_valid_d;
   logic                 idle_gap_q, idle_gap_d;
   logic [31:0]          ok_cnt_q, ok_cnt_d;
   logic [g_LAT_WIDTH-1:0] lat_last_q, lat_last_d, lat_min_q, lat_min_d, lat_max_q, lat_max_d;
   logic                 realign_q, realign_d, pass_q, pass_d, fail_q, fail_d;
   logic [2:0]           fail_code_q, fail_code_d;

   logic                 is_idle, is_payload, buf_err;
   logic [W-1:0]         exp_data;
   logic [g_LAT_WIDTH-1:0] lat;
   logic [2:0]           cause;
   logic                 unused_bufstatus;

   assign unused_bufstatus = ^rx_bufstatus_i;

`ifdef GT_LATENCY_MONITOR_BUFSTATUS_EN
   assign buf_err = rx_bufstatus_i[2];
`else
   assign buf_err = 1'b0;
`endif

   assign is_idle    = (rx_k_i == g_IDLE_K) && (rx_data_i == g_IDLE);
   assign is_payload = (rx_k_i == '0);
   // An IDLE consumed one counter value on TX, so the payload skips by two.
   assign exp_data   = prev_q + (idle_gap_q ? W'(2) : W'(1));
   assign lat        = g_LAT_WIDTH'(tx_cnt - rx_data_i);

   // Lowest code wins, except alignment loss which overrides everything.
   always_comb begin
      cause = FAIL_NONE;
      if (buf_err) cause = FAIL_BUFFER;
      if ((rx_k_i == g_IDLE_K && rx_data_i != g_IDLE) ||
          (is_payload && prev_valid_q && rx_data_i != exp_data)) cause = FAIL_DATA;
      if (!is_payload && rx_k_i != g_IDLE_K) cause = FAIL_COMMA_BYTE;
      if (!rx_aligned_i) cause = FAIL_ALIGN_LOST;
   end

   always_comb begin
      state_d      = state_q;
      blind_d      = blind_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      idle_gap_d   = idle_gap_q;
      ok_cnt_d     = ok_cnt_q;
      lat_last_d   = lat_last_q;
      lat_min_d    = lat_min_q;
      lat_max_d    = lat_max_q;
      fail_code_d  = fail_code_q;

      case (state_q)
         S_DOWN:  if (valid_i) state_d = S_ALIGN;
         S_ALIGN: begin
            if (rx_aligned_i) begin
               state_d = S_BLIND;
               blind_d = '0;
            end
         end
         S_BLIND: begin
            if (!rx_aligned_i) state_d = S_ALIGN;
            else if (blind_q == BW'(g_BLIND_PERIOD)) state_d = S_SEEK;
            else blind_d = blind_q + 1'b1;
         end
         S_SEEK: begin
            if (!rx_aligned_i) state_d = S_ALIGN;
            else if (is_idle) state_d = S_CHECK;
         end
         S_CHECK, S_PASS: begin
            if (is_payload) begin
               lat_last_d = lat;
               lat_min_d  = (lat < lat_min_q) ? lat : lat_min_q;
               lat_max_d  = (lat > lat_max_q) ? lat : lat_max_q;
            end
            if (cause != FAIL_NONE) begin
               state_d     = S_FAIL;
               fail_code_d = cause;
            end else if (is_payload) begin
               if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + 32'd1;
               if (ok_cnt_d > g_NUM_SUCCESSFUL_DATA) state_d = S_PASS;
            end
         end
         S_FAIL:  state_d = S_FAIL;
         default: state_d = S_DOWN;
      endcase

      // Continuity reference is tracked in every state so checking can start at once.
      if (is_payload) begin
         prev_d       = rx_data_i;
         prev_valid_d = 1'b1;
         idle_gap_d   = 1'b0;
      end else if (is_idle) begin
         idle_gap_d = 1'b1;
      end

      if (!valid_i || clear_i) begin
         state_d     = S_DOWN;
         ok_cnt_d    = '0;
         lat_last_d  = '0;
         lat_min_d   = '1;
         lat_max_d   = '0;
         fail_code_d = FAIL_NONE;
      end
      if (state_d == S_DOWN || state_d == S_ALIGN) prev_valid_d = 1'b0;

      realign_d = (state_d == S_ALIGN);
      pass_d    = (state_d == S_PASS);
      fail_d    = (state_d == S_FAIL);
   end

   always_ff @(posedge usrclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_DOWN;
         blind_q      <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         idle_gap_q   <= 1'b0;
         ok_cnt_q     <= '0;
         lat_last_q   <= '0;
         lat_min_q    <= '1;
         lat_max_q    <= '0;
         realign_q    <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         fail_code_q  <= FAIL_NONE;
      end else begin
         state_q      <= state_d;
         blind_q      <= blind_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         idle_gap_q   <= idle_gap_d;
         ok_cnt_q     <= ok_cnt_d;
         lat_last_q   <= lat_last_d;
         lat_min_q    <= lat_min_d;
         lat_max_q    <= lat_max_d;
         realign_q    <= realign_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         fail_code_q  <= fail_code_d;
      end
   end

   assign rx_realign_o   = realign_q;
   assign pass_o         = pass_q;
   assign fail_o         = fail_q;
   assign fail_code_o    = fail_code_q;
   assign latency_last_o = lat_last_q;
   assign latency_min_o  = lat_min_q;
   assign latency_max_o  = lat_max_q;
   assign ok_cnt_o       = ok_cnt_q;

endmodule

// File: tb/tb_gt_latency_monitor.sv
// Bench for gt_latency_monitor: a 2-byte instance in 7-cycle loopback with
// directed faults, and a 4-byte instance whose RX payload is offset so the
// checked sequence wraps past 2^32.
module tb_gt_latency_monitor;
   import gt_latency_monitor_pkg::*;

   localparam logic [15:0] IDLE2   = 16'hbc95;
   localparam logic [1:0]  IDLE_K2 = 2'b10;
   localparam logic [31:0] OFF4    = 32'hffff_ff00;
   localparam int          DLY     = 7;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // 2-byte DUT
   logic        valid2, clear2, aligned2, realign2, pass2, fail2;
   logic [15:0] tx_data2, rx_data2, last2, min2, max2;
   logic [1:0]  tx_k2, rx_k2;
   logic [2:0]  buf2, code2;
   logic [31:0] ok2;
   // 4-byte DUT
   logic        valid4, clear4, aligned4, realign4, pass4, fail4;
   logic [31:0] tx_data4, rx_data4, ok4;
   logic [15:0] last4, min4, max4;
   logic [3:0]  tx_k4, rx_k4;
   logic [2:0]  buf4, code4;

   gt_latency_monitor #(.g_BYTES(2)) dut2 (
      .usrclk_i(clk), .rst_n_i(rst_n), .valid_i(valid2), .clear_i(clear2),
      .tx_data_o(tx_data2), .tx_k_o(tx_k2), .rx_data_i(rx_data2), .rx_k_i(rx_k2),
      .rx_realign_o(realign2), .rx_aligned_i(aligned2), .rx_bufstatus_i(buf2),
      .pass_o(pass2), .fail_o(fail2), .fail_code_o(code2), .latency_last_o(last2),
      .latency_min_o(min2), .latency_max_o(max2), .ok_cnt_o(ok2)
   );

   gt_latency_monitor #(.g_BYTES(4)) dut4 (
      .usrclk_i(clk), .rst_n_i(rst_n), .valid_i(valid4), .clear_i(clear4),
      .tx_data_o(tx_data4), .tx_k_o(tx_k4), .rx_data_i(rx_data4), .rx_k_i(rx_k4),
      .rx_realign_o(realign4), .rx_aligned_i(aligned4), .rx_bufstatus_i(buf4),
      .pass_o(pass4), .fail_o(fail4), .fail_code_o(code4), .latency_last_o(last4),
      .latency_min_o(min4), .latency_max_o(max4), .ok_cnt_o(ok4)
   );

   // Loopback history: index k holds the TX word from k cycles ago.
   logic [15:0] h2_d [0:8];
   logic [1:0]  h2_k [0:8];
   logic [31:0] h4_d [0:7];
   logic [3:0]  h4_k [0:7];

   // TX scoreboard: expected {k, data} pushed before each edge, popped after it.
   logic [17:0] exp_q [$];
   logic [15:0] m_cnt = '0;
   int          m_phase = 0;

   logic drop_arm = 1'b0, swap_arm = 1'b0, injected = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [17:0] e;
      e = (m_phase == 0) ? {IDLE_K2, IDLE2} : {2'b00, m_cnt};
      exp_q.push_back(e);
      m_cnt   = m_cnt + 16'd1;
      m_phase = (m_phase == 192) ? 0 : m_phase + 1;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("tx_word", {14'd0, tx_k2, tx_data2}, {14'd0, e});
      for (int i = 8; i > 0; i--) begin
         h2_d[i] = h2_d[i-1];
         h2_k[i] = h2_k[i-1];
      end
      h2_d[0] = tx_data2;
      h2_k[0] = tx_k2;
      for (int i = 7; i > 0; i--) begin
         h4_d[i] = h4_d[i-1];
         h4_k[i] = h4_k[i-1];
      end
      h4_d[0] = tx_data4;
      h4_k[0] = tx_k4;

      rx_data2 = h2_d[DLY];
      rx_k2    = h2_k[DLY];
      if (drop_arm && h2_k[6] == 2'b00 && h2_k[7] == 2'b00 && h2_k[8] == 2'b00) begin
         rx_data2 = h2_d[6];
         drop_arm = 1'b0;
         injected = 1'b1;
      end
      if (swap_arm && h2_k[DLY] == IDLE_K2) begin
         rx_data2 = {h2_d[DLY][7:0], h2_d[DLY][15:8]};
         rx_k2    = 2'b01;
         swap_arm = 1'b0;
         injected = 1'b1;
      end
      rx_data4 = (h4_k[DLY] == 4'd0) ? h4_d[DLY] + OFF4 : h4_d[DLY];
      rx_k4    = h4_k[DLY];
   endtask

   task automatic clear_pulse();
      clear2 = 1'b1;
      step();
      clear2 = 1'b0;
   endtask

   task automatic wait_check();
      for (int i = 0; i < 600 && ok2 < 32'd5; i++) step();
      chk("check_reached", {31'd0, ok2 >= 32'd5}, 32'd1);
   endtask

   initial begin
      logic [31:0] ok_before;
      rst_n = 1'b0;
      valid2 = 1'b0; clear2 = 1'b0; aligned2 = 1'b0; buf2 = 3'b000;
      rx_data2 = '0; rx_k2 = '0;
      valid4 = 1'b0; clear4 = 1'b0; aligned4 = 1'b1; buf4 = 3'b000;
      rx_data4 = '0; rx_k4 = '0;
      for (int i = 0; i <= 8; i++) begin
         h2_d[i] = '0;
         h2_k[i] = '0;
      end
      for (int i = 0; i <= 7; i++) begin
         h4_d[i] = '0;
         h4_k[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_data", {16'd0, tx_data2}, 32'd0);
      chk("rst_tx_k", {30'd0, tx_k2}, 32'd0);
      chk("rst_realign", {31'd0, realign2}, 32'd0);
      chk("rst_pass", {31'd0, pass2}, 32'd0);
      chk("rst_fail", {31'd0, fail2}, 32'd0);
      chk("rst_code", {29'd0, code2}, 32'd0);
      chk("rst_last", {16'd0, last2}, 32'd0);
      chk("rst_min", {16'd0, min2}, 32'h0000_ffff);
      chk("rst_max", {16'd0, max2}, 32'd0);
      chk("rst_ok", ok2, 32'd0);
      rst_n  = 1'b1;
      valid4 = 1'b1;

      // Realign request and blind-window alignment loss.
      valid2 = 1'b1;
      repeat (3) step();
      chk("realign_in_align", {31'd0, realign2}, 32'd1);
      aligned2 = 1'b1;
      step();
      chk("realign_falls", {31'd0, realign2}, 32'd0);
      repeat (3) step();
      aligned2 = 1'b0;
      step();
      chk("realign_again_blind", {31'd0, realign2}, 32'd1);
      chk("no_fail_blind_loss", {31'd0, fail2}, 32'd0);

      // Ideal loopback to pass.
      aligned2 = 1'b1;
      for (int i = 0; i < 3000 && !pass2 && !fail2; i++) begin
         step();
         chk("pass_fail_excl", {31'd0, pass2 & fail2}, 32'd0);
      end
      chk("pass_reached", {31'd0, pass2}, 32'd1);
      chk("pass_ok_cnt", ok2, 32'd1001);
      chk("lat_min", {16'd0, min2}, 32'd7);
      chk("lat_max", {16'd0, max2}, 32'd7);
      chk("lat_last", {16'd0, last2}, 32'd7);
      chk("pass_code", {29'd0, code2}, 32'd0);
      chk("pass_no_fail", {31'd0, fail2}, 32'd0);

      // 4-byte instance: checked sequence has wrapped past 2^32 by now.
      chk("w4_no_fail", {31'd0, fail4}, 32'd0);
      chk("w4_lat_min", {16'd0, min4}, 32'h0000_0107);
      chk("w4_lat_max", {16'd0, max4}, 32'h0000_0107);
      chk("w4_ok_progress", {31'd0, ok4 > 32'd500}, 32'd1);

      // Dropped payload word in S_PASS.
      injected = 1'b0;
      drop_arm = 1'b1;
      for (int i = 0; i < 20 && !injected; i++) step();
      ok_before = ok2;
      chk("drop_not_yet", {31'd0, fail2}, 32'd0);
      step();
      chk("drop_fail", {31'd0, fail2}, 32'd1);
      chk("drop_pass_clr", {31'd0, pass2}, 32'd0);
      chk("drop_code", {29'd0, code2}, 32'd2);
      repeat (5) step();
      chk("drop_ok_frozen", ok2, ok_before);
      chk("drop_fail_sticky", {31'd0, fail2}, 32'd1);

      // Clear restarts statistics.
      clear_pulse();
      chk("clr_min", {16'd0, min2}, 32'h0000_ffff);
      chk("clr_max", {16'd0, max2}, 32'd0);
      chk("clr_last", {16'd0, last2}, 32'd0);
      chk("clr_ok", ok2, 32'd0);
      chk("clr_fail", {31'd0, fail2}, 32'd0);
      chk("clr_code", {29'd0, code2}, 32'd0);

      // Comma arriving in the wrong byte.
      wait_check();
      injected = 1'b0;
      swap_arm = 1'b1;
      for (int i = 0; i < 300 && !injected; i++) step();
      chk("swap_not_yet", {31'd0, fail2}, 32'd0);
      step();
      chk("swap_fail", {31'd0, fail2}, 32'd1);
      chk("swap_code", {29'd0, code2}, 32'd1);

      // Alignment lost while checking.
      clear_pulse();
      wait_check();
      aligned2 = 1'b0;
      step();
      aligned2 = 1'b1;
      chk("align_fail", {31'd0, fail2}, 32'd1);
      chk("align_code", {29'd0, code2}, 32'd3);

      // Elastic buffer error while checking.
      clear_pulse();
      wait_check();
      ok_before = ok2;
      buf2 = 3'b101;
      step();
      buf2 = 3'b000;
`ifdef GT_LATENCY_MONITOR_BUFSTATUS_EN
      chk("buf_fail", {31'd0, fail2}, 32'd1);
      chk("buf_code", {29'd0, code2}, 32'd4);
`else
      chk("buf_ignored_fail", {31'd0, fail2}, 32'd0);
      chk("buf_ignored_code", {29'd0, code2}, 32'd0);
      repeat (3) step();
      chk("buf_ignored_counting", {31'd0, ok2 > ok_before}, 32'd1);
`endif

      // valid_i low returns to S_DOWN with statistics cleared.
      valid2 = 1'b0;
      step();
      chk("down_ok", ok2, 32'd0);
      chk("down_fail", {31'd0, fail2}, 32'd0);
      chk("down_min", {16'd0, min2}, 32'h0000_ffff);
      chk("down_realign", {31'd0, realign2}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
